// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding,
// PC width and the default handler entry address.
package intr_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] HANDLER_PC_DEF = 32'h0000_0008;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_ENTER  = 3'd2,
        ST_ISR    = 3'd3,
        ST_RETURN = 3'd4
    } state_e;

endpackage

// File: rtl/intr_sync.sv
// Interrupt request conditioning: sampling flop(s) followed by edge or level
// detection. Define INTR_SYNC_EN to insert a two-flop synchronizer (+2 cycles).
module intr_sync #(
    parameter int EDGE_MODE = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic irq_i,
    output logic event_o
);

`ifdef INTR_SYNC_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    // prev_q only holds a genuine sample once the conditioning chain has filled,
    // so a request held high across reset release is not mistaken for an edge.
    localparam logic [1:0] WARM_MAX = 2'(DEPTH + 1);

    logic       cond_q;
    logic       prev_q;
    logic [1:0] warm_q;
    logic       raw_evt;

    assign raw_evt = (EDGE_MODE != 0) ? (cond_q & ~prev_q & (warm_q == WARM_MAX))
                                      : cond_q;

`ifdef INTR_SYNC_EN
    logic meta_q;
    logic evt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            cond_q <= 1'b0;
            evt_q  <= 1'b0;
        end else begin
            meta_q <= irq_i;
            cond_q <= meta_q;
            evt_q  <= raw_evt;
        end
    end

    assign event_o = evt_q;
`else
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cond_q <= 1'b0;
        end else begin
            cond_q <= irq_i;
        end
    end

    assign event_o = raw_evt;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
            warm_q <= 2'd0;
        end else begin
            prev_q <= cond_q;
            if (warm_q != WARM_MAX) begin
                warm_q <= warm_q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Single-source interrupt controller: latches requests, waits for a clean EXE
// slot, redirects to the handler and back on ERET. Optional macro: INTR_SYNC_EN.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter logic [PC_W-1:0] HANDLER_PC = HANDLER_PC_DEF,
    parameter int              EDGE_MODE  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            interrupter,
    input  logic            exe_valid,
    input  logic [PC_W-1:0] pc_exe,
    input  logic            stall,
    input  logic            eret,
    output logic            flush,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] epc,
    output logic            in_isr,
    output logic            pending
);

    state_e          state_q;
    logic            pending_q;
    logic            pending_d;
    logic            flush_q;
    logic            redirect_q;
    logic [PC_W-1:0] redirect_pc_q;
    logic [PC_W-1:0] epc_q;
    logic            in_isr_q;
    logic            req_evt;
    logic            take;
    logic            ret;

    intr_sync #(
        .EDGE_MODE(EDGE_MODE)
    ) u_sync (
        .clk_i  (clk),
        .rst_i  (rst),
        .irq_i  (interrupter),
        .event_o(req_evt)
    );

    assign take = (state_q == ST_ARM) & exe_valid & ~stall & ~eret;
    assign ret  = (state_q == ST_ISR) & eret & ~stall;

    // A new request arriving in the very cycle the interrupt is taken is kept,
    // so it is serviced after the handler returns rather than lost.
    assign pending_d = (pending_q & ~take) | req_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pending_q     <= 1'b0;
            flush_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            epc_q         <= '0;
            in_isr_q      <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            flush_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pending_q) begin
                        state_q <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (take) begin
                        state_q       <= ST_ENTER;
                        epc_q         <= pc_exe;
                        flush_q       <= 1'b1;
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= HANDLER_PC;
                        in_isr_q      <= 1'b1;
                    end
                end
                ST_ENTER: begin
                    state_q <= ST_ISR;
                end
                ST_ISR: begin
                    if (ret) begin
                        state_q       <= ST_RETURN;
                        flush_q       <= 1'b1;
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= epc_q;
                        in_isr_q      <= 1'b0;
                    end
                end
                ST_RETURN: begin
                    state_q <= pending_q ? ST_ARM : ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign flush       = flush_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign epc         = epc_q;
    assign in_isr      = in_isr_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural model of the interrupt entry/return rules.
module tb_intr_ctrl;

`ifdef INTR_SYNC_EN
    localparam int LAT_D = 2;
`else
    localparam int LAT_D = 0;
`endif
    localparam int          LAT = 3 + LAT_D;
    localparam logic [31:0] HPC = 32'h0000_0008;

    logic        clk = 1'b0;
    logic        rst;
    logic        interrupter;
    logic        exe_valid;
    logic [31:0] pc_exe;
    logic        stall;
    logic        eret;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] epc;
    logic        in_isr;
    logic        pending;

    intr_ctrl #(
        .HANDLER_PC(HPC),
        .EDGE_MODE (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .interrupter(interrupter),
        .exe_valid  (exe_valid),
        .pc_exe     (pc_exe),
        .stall      (stall),
        .eret       (eret),
        .flush      (flush),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .epc        (epc),
        .in_isr     (in_isr),
        .pending    (pending)
    );

    always #10 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int unsigned cyc;
        logic [31:0] pc;
        logic [31:0] epc;
        bit          isr;
    } exp_t;
    exp_t sb[$];

    // Behavioural model: which phase of the interrupt sequence we are in,
    // the request latch, the saved PC and a short history of sampled requests.
    bit          m_pending, m_armed, m_entering, m_handling, m_returning;
    logic [31:0] m_epc;
    bit   [3:0]  m_hist;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        bit evt, take, ret, idle;
        bit n_pend, n_arm, n_ent, n_hnd, n_ret;
        logic [31:0] n_epc;
        n_pend = 0; n_arm = 0; n_ent = 0; n_hnd = 0; n_ret = 0; n_epc = '0;
        if (!rst) begin
            // A request event is a 0->1 step between two post-reset samples.
            evt  = (m_cnt >= LAT_D + 2) && m_hist[LAT_D] && !m_hist[LAT_D+1];
            idle = !(m_armed || m_entering || m_handling || m_returning);
            take = m_armed && exe_valid && !stall && !eret;
            ret  = m_handling && eret && !stall;
            n_ent  = take;
            n_hnd  = m_entering || (m_handling && !ret);
            n_ret  = ret;
            n_arm  = (m_armed && !take) || ((idle || m_returning) && m_pending);
            n_pend = (m_pending && !take) || evt;
            n_epc  = take ? pc_exe : m_epc;
            if (take) sb.push_back('{cyc + 1, HPC, pc_exe, 1'b1});
            if (ret)  sb.push_back('{cyc + 1, m_epc, m_epc, 1'b0});
        end
        @(posedge clk);
        m_pending = n_pend; m_armed = n_arm; m_entering = n_ent;
        m_handling = n_hnd; m_returning = n_ret; m_epc = n_epc;
        m_hist = {m_hist[2:0], rst ? 1'b0 : interrupter};
        m_cnt  = rst ? 0 : ((m_cnt < 100) ? m_cnt + 1 : m_cnt);
        #1;
    endtask

    task automatic wait_redirect(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (redirect === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n < 0) begin
            failures++;
            checks++;
            $display("FAIL redirect_timeout actual=none required=redirect within %0d cycles", max);
        end
    endtask

    task automatic pulse();
        interrupter = 1'b1;
        tick();
        interrupter = 1'b0;
    endtask

    task automatic leave_isr();
        eret = 1'b1;
        stall = 1'b0;
        tick();
        eret = 1'b0;
        tick();
        tick();
    endtask

    // Monitor: every cycle, compare the DUT against the model and scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_pulse;
            exp_t e;
            exp_pulse = (sb.size() > 0) && (sb[0].cyc == cyc);
            chk("redirect", {31'd0, redirect}, {31'd0, exp_pulse});
            chk("flush", {31'd0, flush}, {31'd0, exp_pulse});
            if (exp_pulse) begin
                e = sb.pop_front();
                chk("redirect_pc", redirect_pc, e.pc);
                chk("epc_at_redirect", epc, e.epc);
                chk("in_isr_at_redirect", {31'd0, in_isr}, {31'd0, e.isr});
            end
            chk("pending", {31'd0, pending}, {31'd0, m_pending});
            chk("in_isr", {31'd0, in_isr}, {31'd0, m_entering || m_handling});
            chk("epc", epc, m_epc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1; interrupter = 1'b0; exe_valid = 1'b0; pc_exe = '0;
        stall = 1'b0; eret = 1'b0;
        m_pending = 0; m_armed = 0; m_entering = 0; m_handling = 0;
        m_returning = 0; m_epc = '0; m_hist = '0; m_cnt = 0;
        repeat (3) tick();
        mon_en = 1'b1;
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_in_isr", {31'd0, in_isr}, 32'd0);
        chk("rst_pending", {31'd0, pending}, 32'd0);

        // Single pulse on an idle pipeline.
        rst = 1'b0; exe_valid = 1'b1; pc_exe = 32'h0000_0040;
        repeat (4) tick();
        pulse();
        wait_redirect(10, n);
        chk("entry_latency", n, LAT);
        chk("entry_pc", redirect_pc, 32'h0000_0008);
        chk("entry_epc", epc, 32'h0000_0040);
        chk("entry_in_isr", {31'd0, in_isr}, 32'd1);
        tick(); tick();

        // Second request while in the handler, then return and re-entry.
        pulse();
        repeat (3) tick();
        pc_exe = 32'h0000_0200;
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("return_redirect", {31'd0, redirect}, 32'd1);
        chk("return_pc", redirect_pc, 32'h0000_0040);
        wait_redirect(6, n);
        chk("reentry_pc", redirect_pc, 32'h0000_0008);
        chk("reentry_epc", epc, 32'h0000_0200);
        tick();
        leave_isr();
        repeat (3) tick();

        // ERET with no handler active.
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("idle_eret_redirect", {31'd0, redirect}, 32'd0);
        chk("idle_eret_in_isr", {31'd0, in_isr}, 32'd0);
        tick();

        // Request pending while the pipeline is stalled.
        stall = 1'b1; pc_exe = 32'h0000_0080;
        pulse();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("stall_no_redirect", {31'd0, redirect}, 32'd0);
        end
        stall = 1'b0; pc_exe = 32'h0000_0100;
        wait_redirect(4, n);
        chk("stall_take_latency", n, 1);
        chk("stall_epc", epc, 32'h0000_0100);
        tick();
        leave_isr();

        // Reset during the handler with the request held high across release.
        pulse();
        wait_redirect(10, n);
        tick(); tick();
        interrupter = 1'b1;
        rst = 1'b1;
        tick();
        chk("rst_isr_in_isr", {31'd0, in_isr}, 32'd0);
        chk("rst_isr_epc", epc, 32'd0);
        chk("rst_isr_redirect", {31'd0, redirect}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("held_high_pending", {31'd0, pending}, 32'd0);
        chk("held_high_in_isr", {31'd0, in_isr}, 32'd0);
        interrupter = 1'b0;
        repeat (3) tick();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            interrupter = ($urandom_range(0, 7) == 0);
            exe_valid   = ($urandom_range(0, 3) != 0);
            stall       = ($urandom_range(0, 3) == 0);
            eret        = m_handling ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
            pc_exe      = $urandom & 32'hFFFF_FFFC;
            rst         = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; interrupter = 1'b0; eret = 1'b0; stall = 1'b0;
        repeat (6) tick();
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
